arb8_rr_ctrl: RTL and testbench
===============================

ARB8_RR_CTRL -- requirements
Module: arb8_rr_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant (legal range 2..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  8  request vector; bit i = requester i wants the shared 8:1 mux path.
REQ-005 Port: done  input  1  current owner releases the grant this cycle.
REQ-006 Port: grant  output  8  one-hot grant vector, all-zero when idle.
REQ-007 Port: sel  output  3  binary index of owner; drives the 8:1 mux select.
REQ-008 Port: gnt_valid  output  1  high while any grant is held.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Function
REQ-010 Two states SHALL exist: IDLE (no owner) and BUSY (owner held in a registered index).
REQ-011 All outputs SHALL be registered; grant, sel and gnt_valid SHALL be mutually consistent every cycle (grant = 1<<sel when gnt_valid, else grant = 0).
REQ-012 Arbitration SHALL be round-robin: winner = first set bit of the candidate vector scanning upward from pointer ptr, wrapping 7 -> 0.
REQ-013 IDLE with req != 0 SHALL enter BUSY next cycle with the winner granted (request-to-grant latency 1 cycle).
REQ-014 IDLE with req == 0 SHALL remain IDLE; sel SHALL hold its last value.
REQ-015 On every new grant ptr SHALL update to (winner + 1) mod 8.
REQ-016 BUSY SHALL hold grant, sel unchanged until a release event: done=1, req[sel]=0, or hold counter = MAX_HOLD-1.
REQ-017 The hold counter SHALL clear on each new grant and increment once per BUSY cycle, saturating at MAX_HOLD-1.
REQ-018 On a release event the candidate vector SHALL be req with bit sel masked; if non-zero the new winner SHALL be granted on the next cycle (no idle bubble), else the block SHALL go IDLE.
REQ-019 Release by counter with done=0 and req[sel]=1 SHALL pulse timeout for exactly the cycle the new state takes effect; done or req drop in the same cycle SHALL suppress timeout.
REQ-020 A requester released by timeout SHALL be eligible again only after other pending requesters have been served per REQ-012/REQ-015.
REQ-021 done asserted while IDLE SHALL be ignored.
REQ-022 Sole requester releasing and re-requesting SHALL be re-granted one cycle after the block enters IDLE.

Reset
REQ-023 With rst=1 at a clock edge: state=IDLE, ptr=0, hold counter=0, grant=8'h00, sel=3'd0, gnt_valid=0, timeout=0.
REQ-024 Reset SHALL take priority over all other inputs, including mid-grant; first grant after reset SHALL use ptr=0.

Structure
REQ-025 State encodings and the requester count (8) SHALL live in the shared project header of constants; MAX_HOLD remains a module parameter.
REQ-026 The first-set-bit-from-pointer search SHALL be a combinational sub-module rr_prio_enc8 (inputs vector[7:0], ptr[2:0]; outputs idx[2:0], any).

Verification
REQ-027 Reset then req=8'b0000_0100 -> one cycle later grant=8'h04, sel=2, gnt_valid=1; ptr=3.
REQ-028 ptr=3, req=8'b1000_0011 held, done pulsed each grant -> grants sel 7, 0, 1, 7 back-to-back with no idle cycle.
REQ-029 MAX_HOLD=4, req=8'h01 held and done=0 -> grant held 4 cycles, timeout pulses once, block goes IDLE, re-grants sel=0 next cycle.
REQ-030 MAX_HOLD=4, req=8'h11 held, done=0 -> sel=0 for 4 cycles, timeout pulse, sel=4 granted the following cycle.
REQ-031 BUSY with sel=5, rst=1 for one cycle -> next cycle grant=0, gnt_valid=0, sel=0; with req=8'hFF thereafter grant=8'h01.
REQ-032 Every cycle of every test: grant one-hot or zero, grant==(gnt_valid ? 1<<sel : 0), timeout never high two consecutive cycles.

Source files
------------

// File: rtl/arb8_rr_ctrl_pkg.sv
// rtl/arb8_rr_ctrl_pkg.sv - shared constants and state encoding for the 8-way round-robin arbiter
package arb8_rr_ctrl_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/arb8_rr_ctrl_prio_enc.sv
// rtl/arb8_rr_ctrl_prio_enc.sv - first set bit of an 8-bit vector scanning upward from ptr, wrapping 7 -> 0
module rr_prio_enc8
   import arb8_rr_ctrl_pkg::*;
(
   input  logic [N_REQ-1:0] vector,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the farthest offset down so the nearest set bit to ptr is written last.
   always_comb begin
      idx = ptr;
      any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (vector[ptr + 3'(k)]) begin
            idx = ptr + 3'(k);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb8_rr_ctrl.sv
// rtl/arb8_rr_ctrl.sv - 8-requester round-robin arbiter with done/drop release and MAX_HOLD revocation
module arb8_rr_ctrl
   import arb8_rr_ctrl_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] sel,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   arb_state_t       r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [7:0]       r_cnt;
   logic [N_REQ-1:0] r_grant;
   logic [IDX_W-1:0] r_sel;
   logic             r_valid;
   logic             r_timeout;

   logic [N_REQ-1:0] w_cand;
   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic             w_at_limit;
   logic             w_release;
   logic             w_forced;

   // The current owner is never a candidate for its own successor.
   assign w_cand     = (r_state == ST_BUSY) ? (req & ~idx_to_onehot(r_sel)) : req;
   assign w_at_limit = (r_cnt == HOLD_LAST);
   assign w_release  = done || !req[r_sel] || w_at_limit;
   assign w_forced   = w_at_limit && !done && req[r_sel];

   rr_prio_enc8 u_prio_enc (
      .vector (w_cand),
      .ptr    (r_ptr),
      .idx    (w_idx),
      .any    (w_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_grant   <= '0;
         r_sel     <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         if (r_state == ST_IDLE || w_release) begin
            if (r_state == ST_BUSY) begin
               r_timeout <= w_forced;
            end
            if (w_any) begin
               r_state <= ST_BUSY;
               r_sel   <= w_idx;
               r_grant <= idx_to_onehot(w_idx);
               r_valid <= 1'b1;
               r_ptr   <= w_idx + 3'd1;
               r_cnt   <= '0;
            end else begin
               // sel keeps the last owner while idle
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_valid <= 1'b0;
            end
         end else if (r_cnt != HOLD_LAST) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign grant     = r_grant;
   assign sel       = r_sel;
   assign gnt_valid = r_valid;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// tb/tb_arb8_rr_ctrl.sv - self-checking bench for arb8_rr_ctrl against a rule-level reference model
module tb_arb8_rr_ctrl;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int failures = 0;

   bit m_valid = 0;
   int m_sel = 0;
   int m_ptr = 0;
   int m_hold = 0;
   bit m_to = 0;

   bit inv_en = 0;
   bit prev_to = 0;

   arb8_rr_ctrl #(.MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .sel       (sel),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(input logic [7:0] v, input int p);
      for (int k = 0; k < 8; k++) begin
         if (v[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [7:0] exp_grant();
      logic [7:0] one;
      one = 8'h01;
      return m_valid ? (one << m_sel) : 8'h00;
   endfunction

   task automatic model_grant(input int w);
      m_valid = 1;
      m_sel   = w;
      m_ptr   = (w + 1) % 8;
      m_hold  = 0;
   endtask

   task automatic step(input logic [7:0] r, input logic d, input logic rs);
      logic [7:0] cand;
      bit lim;
      int w;
      req  = r;
      done = d;
      rst  = rs;
      @(posedge clk);
      if (rs) begin
         m_valid = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (!m_valid) begin
            w = rr_pick(r, m_ptr);
            if (w >= 0) model_grant(w);
         end else begin
            lim = (m_hold == MAXH - 1);
            if (d || !r[m_sel] || lim) begin
               m_to = lim && !d && r[m_sel];
               cand = r;
               cand[m_sel] = 1'b0;
               w = rr_pick(cand, m_ptr);
               if (w >= 0) model_grant(w);
               else m_valid = 0;
            end else begin
               m_hold = (m_hold + 1 > MAXH - 1) ? MAXH - 1 : m_hold + 1;
            end
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (inv_en) begin
         checks++;
         if (!$onehot0(grant)) begin
            failures++;
            $display("FAIL inv_onehot: grant=%h is not one-hot or zero", grant);
         end
         checks++;
         if (grant !== (gnt_valid ? (8'h01 << sel) : 8'h00)) begin
            failures++;
            $display("FAIL inv_consistent: grant=%h sel=%0d gnt_valid=%b", grant, sel, gnt_valid);
         end
         checks++;
         if (prev_to && timeout) begin
            failures++;
            $display("FAIL inv_timeout_width: timeout high on two consecutive cycles");
         end
         prev_to = timeout;
      end
   end

   task automatic test_reset();
      step(8'h00, 1'b0, 1'b1);
      step(8'hFF, 1'b1, 1'b1);
      inv_en = 1;
      checks++;
      if (grant !== 8'h00 || sel !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: grant=%h sel=%0d valid=%b to=%b expected 00/0/0/0", grant, sel, gnt_valid, timeout);
      end
   endtask

   task automatic test_first_grant();
      step(8'b0000_0100, 1'b0, 1'b0);
      checks++;
      if (grant !== 8'h04 || sel !== 3'd2 || gnt_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_grant: grant=%h sel=%0d valid=%b expected 04/2/1", grant, sel, gnt_valid);
      end
   endtask

   task automatic test_rr_sequence();
      logic [2:0] exp_sel [4] = '{3'd7, 3'd0, 3'd1, 3'd7};
      for (int i = 0; i < 4; i++) begin
         step(8'b1000_0011, 1'b1, 1'b0);
         checks++;
         if (sel !== exp_sel[i] || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL rr_seq[%0d]: sel=%0d valid=%b expected sel=%0d valid=1", i, sel, gnt_valid, exp_sel[i]);
         end
      end
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (gnt_valid !== 1'b0 || grant !== 8'h00 || sel !== 3'd7) begin
         failures++;
         $display("FAIL idle_sel_hold: grant=%h sel=%0d valid=%b expected 00/7/0", grant, sel, gnt_valid);
      end
   endtask

   task automatic test_done_idle();
      step(8'h00, 1'b1, 1'b0);
      checks++;
      if (gnt_valid !== 1'b0 || timeout !== 1'b0 || sel !== 3'd7) begin
         failures++;
         $display("FAIL done_idle: valid=%b to=%b sel=%0d expected 0/0/7", gnt_valid, timeout, sel);
      end
   endtask

   task automatic test_timeout_single();
      step(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < MAXH; i++) begin
         step(8'h01, 1'b0, 1'b0);
         checks++;
         if (grant !== 8'h01 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_single_hold[%0d]: grant=%h to=%b expected 01/0", i, grant, timeout);
         end
      end
      step(8'h01, 1'b0, 1'b0);
      checks++;
      if (timeout !== 1'b1 || gnt_valid !== 1'b0 || grant !== 8'h00) begin
         failures++;
         $display("FAIL to_single_revoke: to=%b valid=%b grant=%h expected 1/0/00", timeout, gnt_valid, grant);
      end
      step(8'h01, 1'b0, 1'b0);
      checks++;
      if (timeout !== 1'b0 || grant !== 8'h01 || sel !== 3'd0) begin
         failures++;
         $display("FAIL to_single_regrant: to=%b grant=%h sel=%0d expected 0/01/0", timeout, grant, sel);
      end
   endtask

   task automatic test_timeout_pair();
      step(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < MAXH; i++) begin
         step(8'h11, 1'b0, 1'b0);
         checks++;
         if (sel !== 3'd0 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_pair_hold[%0d]: sel=%0d valid=%b to=%b expected 0/1/0", i, sel, gnt_valid, timeout);
         end
      end
      step(8'h11, 1'b0, 1'b0);
      checks++;
      if (sel !== 3'd4 || grant !== 8'h10 || timeout !== 1'b1) begin
         failures++;
         $display("FAIL to_pair_switch: sel=%0d grant=%h to=%b expected 4/10/1", sel, grant, timeout);
      end
   endtask

   task automatic test_suppress_and_regrant();
      step(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < MAXH; i++) step(8'h01, 1'b0, 1'b0);
      step(8'h01, 1'b1, 1'b0);
      checks++;
      if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_suppressed: to=%b valid=%b expected 0/0", timeout, gnt_valid);
      end
      step(8'h01, 1'b0, 1'b0);
      checks++;
      if (grant !== 8'h01 || gnt_valid !== 1'b1) begin
         failures++;
         $display("FAIL sole_regrant: grant=%h valid=%b expected 01/1", grant, gnt_valid);
      end
   endtask

   task automatic test_reset_mid_grant();
      step(8'h00, 1'b0, 1'b1);
      step(8'h20, 1'b0, 1'b0);
      checks++;
      if (sel !== 3'd5 || grant !== 8'h20) begin
         failures++;
         $display("FAIL mid_setup: sel=%0d grant=%h expected 5/20", sel, grant);
      end
      step(8'h20, 1'b0, 1'b1);
      checks++;
      if (grant !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd0) begin
         failures++;
         $display("FAIL mid_reset: grant=%h valid=%b sel=%0d expected 00/0/0", grant, gnt_valid, sel);
      end
      step(8'hFF, 1'b0, 1'b0);
      checks++;
      if (grant !== 8'h01) begin
         failures++;
         $display("FAIL post_reset_grant: grant=%h expected 01", grant);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic d, rs;
      r = 8'h00;
      step(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
         d  = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 99) == 0);
         step(r, d, rs);
         checks++;
         if (grant !== exp_grant() || sel !== 3'(m_sel) || gnt_valid !== m_valid || timeout !== m_to) begin
            failures++;
            $display("FAIL random[%0d]: req=%h done=%b rst=%b got grant=%h sel=%0d valid=%b to=%b expected %h/%0d/%b/%b",
                     i, r, d, rs, grant, sel, gnt_valid, timeout, exp_grant(), m_sel, m_valid, m_to);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_rr_sequence();
      test_done_idle();
      test_timeout_single();
      test_timeout_pair();
      test_suppress_and_regrant();
      test_reset_mid_grant();
      test_random();
      @(negedge clk);
      inv_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
